// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the decode/control stage and the pipeline sequencer.
// The master side (decode, EX and MEM stage status) drives the hazard sources.
// The slave side (the sequencer) returns the pipeline-register controls.
//   dec_*        : decoded ID instruction and its source-register usage
//   ex_*         : EX instruction load/write-back status and destination
//   br_taken     : EX resolved a taken branch / branch-with-link
//   mem_req/ack  : MEM stage data-memory request and completion
//   stall_*      : hold the IF/ID, ID/EX and EX/MEM registers
//   bubble_ex    : load a NOP into ID/EX
//   flush_*      : squash the IF/ID or ID/EX contents
//   mem_timeout  : sticky error, a data access was abandoned
//   state_o      : sequencer FSM state (RUN=0, MEM_WAIT=1, FLUSH=2)
interface pipeline_sequencer_if #(
    parameter int REG_ADDR_W = 4
);
    logic                  dec_valid;
    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [REG_ADDR_W-1:0] dec_rs2;
    logic                  dec_use_rs1;
    logic                  dec_use_rs2;
    logic                  ex_load;
    logic                  ex_we;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  br_taken;
    logic                  mem_req;
    logic                  mem_ack;
    logic                  stall_if;
    logic                  stall_id;
    logic                  stall_ex;
    logic                  bubble_ex;
    logic                  flush_id;
    logic                  flush_ex;
    logic                  mem_timeout;
    logic [1:0]            state_o;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
        output ex_load, ex_we, ex_rd, br_taken, mem_req, mem_ack,
        input  stall_if, stall_id, stall_ex, bubble_ex, flush_id, flush_ex,
        input  mem_timeout, state_o
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
        input  ex_load, ex_we, ex_rd, br_taken, mem_req, mem_ack,
        output stall_if, stall_id, stall_ex, bubble_ex, flush_id, flush_ex,
        output mem_timeout, state_o
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer for the 5-stage pipeline, sitting beside the control unit.
// Generates stall, bubble and flush controls from load-use hazards, multi-cycle
// data-memory accesses and taken branches. Controls are combinational from the
// current state and inputs; only the FSM state and its counters are registered.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous reset, active low; forces all controls to 0 while low
//   bus    : pipeline_sequencer_if slave modport (hazard sources in, controls out)
// FLUSH_CYCLES is limited to 256 and MEM_TIMEOUT to 255 by the 8-bit counters.
module pipeline_sequencer #(
    parameter int REG_ADDR_W   = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [7:0] FLUSH_LOAD  = 8'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            wait_cnt;
    logic [7:0]            wait_cnt_nxt;
    logic [7:0]            flush_cnt;
    logic [7:0]            flush_cnt_nxt;
    logic                  timeout_q;
    logic                  timeout_nxt;

    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  hazard;
    logic                  mem_miss;

    logic ctl_stall_if;
    logic ctl_stall_id;
    logic ctl_stall_ex;
    logic ctl_bubble_ex;
    logic ctl_flush_id;
    logic ctl_flush_ex;

    assign rs1 = bus.dec_rs1;
    assign rs2 = bus.dec_rs2;
    assign rd  = bus.ex_rd;

    // Load-use hazard: the loaded value is not available for the ID read yet.
    assign hazard = bus.dec_valid & bus.ex_load & bus.ex_we &
                    ((bus.dec_use_rs1 & (rs1 == rd)) | (bus.dec_use_rs2 & (rs2 == rd)));

    // An access completing in its issue cycle needs no wait.
    assign mem_miss = bus.mem_req & ~bus.mem_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            flush_cnt <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        flush_cnt_nxt = flush_cnt;
        timeout_nxt   = timeout_q;
        ctl_stall_if  = 1'b0;
        ctl_stall_id  = 1'b0;
        ctl_stall_ex  = 1'b0;
        ctl_bubble_ex = 1'b0;
        ctl_flush_id  = 1'b0;
        ctl_flush_ex  = 1'b0;

        case (state)
            RUN: begin
                if (mem_miss) begin
                    ctl_stall_if = 1'b1;
                    ctl_stall_id = 1'b1;
                    ctl_stall_ex = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end else if (bus.br_taken) begin
                    ctl_flush_id = 1'b1;
                    ctl_flush_ex = 1'b1;
                    // The resolve cycle is the first flush cycle; FLUSH covers the rest.
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = FLUSH_LOAD;
                    end
                end else if (hazard) begin
                    ctl_stall_if  = 1'b1;
                    ctl_stall_id  = 1'b1;
                    ctl_bubble_ex = 1'b1;
                end
            end
            MEM_WAIT: begin
                // EX is frozen, so branches and hazards are re-evaluated back in RUN.
                ctl_stall_if = 1'b1;
                ctl_stall_id = 1'b1;
                ctl_stall_ex = 1'b1;
                if (bus.mem_ack) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    timeout_nxt  = 1'b1;
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            FLUSH: begin
                // Instructions in ID/EX here are squashed, so their requests are ignored.
                ctl_flush_id  = 1'b1;
                flush_cnt_nxt = flush_cnt - 8'd1;
                if (flush_cnt == 8'd1) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (!rst_n) begin
            ctl_stall_if  = 1'b0;
            ctl_stall_id  = 1'b0;
            ctl_stall_ex  = 1'b0;
            ctl_bubble_ex = 1'b0;
            ctl_flush_id  = 1'b0;
            ctl_flush_ex  = 1'b0;
        end
    end

    assign bus.stall_if    = ctl_stall_if;
    assign bus.stall_id    = ctl_stall_id;
    assign bus.stall_ex    = ctl_stall_ex;
    assign bus.bubble_ex   = ctl_bubble_ex;
    assign bus.flush_id    = ctl_flush_id;
    assign bus.flush_ex    = ctl_flush_ex;
    assign bus.mem_timeout = timeout_q;
    assign bus.state_o     = state;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer (REG_ADDR_W=4, FLUSH_CYCLES=2, MEM_TIMEOUT=15).
// Each scenario task builds a list of per-cycle stimulus and expected outputs; the
// expected vector is pushed to a scoreboard when its stimulus is driven and popped
// and compared at the following falling edge.
// Output vector layout: {stall_if, stall_id, stall_ex, bubble_ex, flush_id, flush_ex,
//                        mem_timeout, state_o[1:0]}
module tb_pipeline_sequencer;
    typedef struct packed {
        logic       dv;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u1;
        logic       u2;
        logic       ld;
        logic       we;
        logic [3:0] rd;
        logic       br;
        logic       req;
        logic       ack;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] sb[$];

    pipeline_sequencer_if #(.REG_ADDR_W(4)) bus ();

    pipeline_sequencer #(
        .REG_ADDR_W  (4),
        .FLUSH_CYCLES(2),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic stim_t mk_stim(input logic dv, input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic u1, input logic u2, input logic ld, input logic we,
                                      input logic [3:0] rd, input logic br, input logic req,
                                      input logic ack);
        stim_t s;
        s = '{dv, rs1, rs2, u1, u2, ld, we, rd, br, req, ack};
        return s;
    endfunction

    function automatic logic [8:0] mk_exp(input logic si, input logic sid, input logic sex,
                                          input logic bub, input logic fid, input logic fex,
                                          input logic tmo, input logic [1:0] st);
        return {si, sid, sex, bub, fid, fex, tmo, st};
    endfunction

    function automatic logic [8:0] outs();
        return {bus.stall_if, bus.stall_id, bus.stall_ex, bus.bubble_ex,
                bus.flush_id, bus.flush_ex, bus.mem_timeout, bus.state_o};
    endfunction

    // Drive one cycle of stimulus just after the rising edge and record its expectation.
    task automatic step(input logic r, input stim_t s, input logic [8:0] e);
        @(posedge clk);
        #1;
        rst_n           = r;
        bus.dec_valid   = s.dv;
        bus.dec_rs1     = s.rs1;
        bus.dec_rs2     = s.rs2;
        bus.dec_use_rs1 = s.u1;
        bus.dec_use_rs2 = s.u2;
        bus.ex_load     = s.ld;
        bus.ex_we       = s.we;
        bus.ex_rd       = s.rd;
        bus.br_taken    = s.br;
        bus.mem_req     = s.req;
        bus.mem_ack     = s.ack;
        sb.push_back(e);
    endtask

    localparam logic [8:0] ZERO   = 9'd0;
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FL   = 2'd2;

    stim_t idle_s, miss_s, ack_s, br_s, haz_s;

    task automatic test_reset();
        stim_t      sq[$];
        logic [8:0] eq[$];
        logic       rq[$];
        logic [8:0] got, want;
        // Active hazard, branch and miss inputs while in reset must not produce controls.
        sq.push_back(mk_stim(1, 3, 0, 1, 0, 1, 1, 3, 1, 1, 0)); rq.push_back(0); eq.push_back(ZERO);
        sq.push_back(mk_stim(1, 3, 0, 1, 0, 1, 1, 3, 1, 1, 0)); rq.push_back(0); eq.push_back(ZERO);
        sq.push_back(idle_s);                                     rq.push_back(1); eq.push_back(ZERO);
        for (int i = 0; i < sq.size(); i++) begin
            step(rq[i], sq[i], eq[i]);
            @(negedge clk);
            got = outs();
            want = (sb.size() != 0) ? sb.pop_front() : 9'h1ff;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t      sq[$];
        logic [8:0] eq[$];
        logic [8:0] got, want;
        logic [8:0] stl;
        stl = mk_exp(1, 1, 0, 1, 0, 0, 0, S_RUN);
        sq.push_back(haz_s);                                      eq.push_back(stl);
        sq.push_back(idle_s);                                     eq.push_back(ZERO);
        sq.push_back(mk_stim(1, 3, 0, 0, 0, 1, 1, 3, 0, 0, 0));   eq.push_back(ZERO);
        sq.push_back(mk_stim(1, 5, 7, 0, 1, 1, 1, 7, 0, 0, 0));   eq.push_back(stl);
        sq.push_back(mk_stim(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));   eq.push_back(stl);
        sq.push_back(mk_stim(1, 3, 0, 1, 0, 1, 0, 3, 0, 0, 0));   eq.push_back(ZERO);
        sq.push_back(mk_stim(0, 3, 0, 1, 0, 1, 1, 3, 0, 0, 0));   eq.push_back(ZERO);
        sq.push_back(mk_stim(1, 3, 0, 1, 0, 0, 1, 3, 0, 0, 0));   eq.push_back(ZERO);
        sq.push_back(mk_stim(1, 3, 4, 1, 1, 1, 1, 9, 0, 0, 0));   eq.push_back(ZERO);
        for (int i = 0; i < sq.size(); i++) begin
            step(1'b1, sq[i], eq[i]);
            @(negedge clk);
            got = outs();
            want = (sb.size() != 0) ? sb.pop_front() : 9'h1ff;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_use[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t      sq[$];
        logic [8:0] eq[$];
        logic [8:0] got, want;
        sq.push_back(miss_s);  eq.push_back(mk_exp(1, 1, 1, 0, 0, 0, 0, S_RUN));
        sq.push_back(idle_s);  eq.push_back(mk_exp(1, 1, 1, 0, 0, 0, 0, S_WAIT));
        sq.push_back(idle_s);  eq.push_back(mk_exp(1, 1, 1, 0, 0, 0, 0, S_WAIT));
        sq.push_back(ack_s);   eq.push_back(mk_exp(1, 1, 1, 0, 0, 0, 0, S_WAIT));
        sq.push_back(idle_s);  eq.push_back(ZERO);
        sq.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); eq.push_back(ZERO);
        sq.push_back(idle_s);  eq.push_back(ZERO);
        for (int i = 0; i < sq.size(); i++) begin
            step(1'b1, sq[i], eq[i]);
            @(negedge clk);
            got = outs();
            want = (sb.size() != 0) ? sb.pop_front() : 9'h1ff;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mem_wait[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t      sq[$];
        logic [8:0] eq[$];
        logic [8:0] got, want;
        logic [8:0] fl0, fl1;
        fl0 = mk_exp(0, 0, 0, 0, 1, 1, 0, S_RUN);
        fl1 = mk_exp(0, 0, 0, 0, 1, 0, 0, S_FL);
        sq.push_back(br_s);   eq.push_back(fl0);
        // Branch, hazard and miss presented during FLUSH belong to squashed instructions.
        sq.push_back(mk_stim(1, 3, 0, 1, 0, 1, 1, 3, 1, 1, 0)); eq.push_back(fl1);
        sq.push_back(idle_s); eq.push_back(ZERO);
        sq.push_back(br_s);   eq.push_back(fl0);
        sq.push_back(br_s);   eq.push_back(fl1);
        sq.push_back(br_s);   eq.push_back(fl0);
        sq.push_back(idle_s); eq.push_back(fl1);
        sq.push_back(idle_s); eq.push_back(ZERO);
        for (int i = 0; i < sq.size(); i++) begin
            step(1'b1, sq[i], eq[i]);
            @(negedge clk);
            got = outs();
            want = (sb.size() != 0) ? sb.pop_front() : 9'h1ff;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL flush[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_priority();
        stim_t      sq[$];
        logic [8:0] eq[$];
        logic [8:0] got, want;
        sq.push_back(mk_stim(1, 3, 0, 1, 0, 1, 1, 3, 1, 0, 0)); eq.push_back(mk_exp(0, 0, 0, 0, 1, 1, 0, S_RUN));
        sq.push_back(idle_s);                                   eq.push_back(mk_exp(0, 0, 0, 0, 1, 0, 0, S_FL));
        sq.push_back(idle_s);                                   eq.push_back(ZERO);
        sq.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0)); eq.push_back(mk_exp(1, 1, 1, 0, 0, 0, 0, S_RUN));
        sq.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1)); eq.push_back(mk_exp(1, 1, 1, 0, 0, 0, 0, S_WAIT));
        sq.push_back(br_s);                                     eq.push_back(mk_exp(0, 0, 0, 0, 1, 1, 0, S_RUN));
        sq.push_back(idle_s);                                   eq.push_back(mk_exp(0, 0, 0, 0, 1, 0, 0, S_FL));
        sq.push_back(idle_s);                                   eq.push_back(ZERO);
        for (int i = 0; i < sq.size(); i++) begin
            step(1'b1, sq[i], eq[i]);
            @(negedge clk);
            got = outs();
            want = (sb.size() != 0) ? sb.pop_front() : 9'h1ff;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL priority[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t      sq[$];
        logic [8:0] eq[$];
        logic [8:0] got, want;
        // Ack on the 15th wait cycle completes the access without an error.
        sq.push_back(miss_s); eq.push_back(mk_exp(1, 1, 1, 0, 0, 0, 0, S_RUN));
        for (int k = 1; k <= 14; k++) begin
            sq.push_back(idle_s); eq.push_back(mk_exp(1, 1, 1, 0, 0, 0, 0, S_WAIT));
        end
        sq.push_back(ack_s);  eq.push_back(mk_exp(1, 1, 1, 0, 0, 0, 0, S_WAIT));
        sq.push_back(idle_s); eq.push_back(ZERO);
        // No ack at all: 15 wait cycles, then abandoned with a sticky error.
        sq.push_back(miss_s); eq.push_back(mk_exp(1, 1, 1, 0, 0, 0, 0, S_RUN));
        for (int k = 1; k <= 15; k++) begin
            sq.push_back(idle_s); eq.push_back(mk_exp(1, 1, 1, 0, 0, 0, 0, S_WAIT));
        end
        sq.push_back(idle_s); eq.push_back(mk_exp(0, 0, 0, 0, 0, 0, 1, S_RUN));
        sq.push_back(idle_s); eq.push_back(mk_exp(0, 0, 0, 0, 0, 0, 1, S_RUN));
        sq.push_back(haz_s);  eq.push_back(mk_exp(1, 1, 0, 1, 0, 0, 1, S_RUN));
        sq.push_back(ack_s);  eq.push_back(mk_exp(0, 0, 0, 0, 0, 0, 1, S_RUN));
        for (int i = 0; i < sq.size(); i++) begin
            step(1'b1, sq[i], eq[i]);
            @(negedge clk);
            got = outs();
            want = (sb.size() != 0) ? sb.pop_front() : 9'h1ff;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL timeout[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t      sq[$];
        logic [8:0] eq[$];
        logic       rq[$];
        logic [8:0] mq[$];
        logic [8:0] got, want;
        // While rst_n is low only the six controls are checked; the registered
        // state and error flag are checked on the cycle after reset.
        sq.push_back(miss_s); rq.push_back(1); mq.push_back(9'h1ff); eq.push_back(mk_exp(1, 1, 1, 0, 0, 0, 1, S_RUN));
        sq.push_back(idle_s); rq.push_back(1); mq.push_back(9'h1ff); eq.push_back(mk_exp(1, 1, 1, 0, 0, 0, 1, S_WAIT));
        sq.push_back(mk_stim(1, 3, 0, 1, 0, 1, 1, 3, 1, 1, 0));
                              rq.push_back(0); mq.push_back(9'h1f8); eq.push_back(ZERO);
        sq.push_back(idle_s); rq.push_back(1); mq.push_back(9'h1ff); eq.push_back(ZERO);
        sq.push_back(br_s);   rq.push_back(1); mq.push_back(9'h1ff); eq.push_back(mk_exp(0, 0, 0, 0, 1, 1, 0, S_RUN));
        sq.push_back(br_s);   rq.push_back(0); mq.push_back(9'h1f8); eq.push_back(ZERO);
        sq.push_back(idle_s); rq.push_back(1); mq.push_back(9'h1ff); eq.push_back(ZERO);
        sq.push_back(br_s);   rq.push_back(1); mq.push_back(9'h1ff); eq.push_back(mk_exp(0, 0, 0, 0, 1, 1, 0, S_RUN));
        sq.push_back(idle_s); rq.push_back(1); mq.push_back(9'h1ff); eq.push_back(mk_exp(0, 0, 0, 0, 1, 0, 0, S_FL));
        sq.push_back(idle_s); rq.push_back(1); mq.push_back(9'h1ff); eq.push_back(ZERO);
        for (int i = 0; i < sq.size(); i++) begin
            step(rq[i], sq[i], eq[i]);
            @(negedge clk);
            got = outs();
            want = (sb.size() != 0) ? sb.pop_front() : 9'h1ff;
            checks++;
            if ((got & mq[i]) !== (want & mq[i])) begin
                errors++;
                $display("FAIL reset_mid[%0d] got=%b want=%b mask=%b", i, got, want, mq[i]);
            end
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.dec_valid   = 1'b0;
        bus.dec_rs1     = 4'd0;
        bus.dec_rs2     = 4'd0;
        bus.dec_use_rs1 = 1'b0;
        bus.dec_use_rs2 = 1'b0;
        bus.ex_load     = 1'b0;
        bus.ex_we       = 1'b0;
        bus.ex_rd       = 4'd0;
        bus.br_taken    = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_ack     = 1'b0;

        idle_s = mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        miss_s = mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        ack_s  = mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        br_s   = mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        haz_s  = mk_stim(1, 3, 0, 1, 0, 1, 1, 3, 0, 0, 0);

        test_reset();
        test_load_use();
        test_mem_wait();
        test_back_to_back();
        test_priority();
        test_timeout();
        test_reset_mid();

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d leftover want=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
